// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit feeding inst_decode.
// Keeps the fetch PC and issues pipelined word reads over a request/grant bus
// with in-order responses. Responses are buffered in a small FIFO that is
// presented to decode. Jumps from EX redirect the PC, and responses that were
// already in flight at the time of the jump are discarded.
// Optional feature: define INST_FETCH_BYPASS_EN to let a response go straight
// to decode in the cycle it arrives when the FIFO is empty.

module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned   PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned   CNT_W     = PTR_W + 1;
  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_addr_q [FIFO_DEPTH];
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];

  logic        fifo_empty;
  logic        grant;
  logic        rsp_acc;
  logic        rsp_live;
  logic        push;
  logic        pop;
  logic [31:0] jump_target;
  logic        unused_jump_lsbs;

  // The low two bits of the jump target are forced to zero.
  assign jump_target      = {jump_addr_i[31:2], 2'b00};
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  // Only request when every in-flight response is guaranteed a FIFO slot.
  assign imem_req_o  = rst_n_i & ~jump_flag_i &
                       (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < DEPTH_LIM);
  assign imem_addr_o = fetch_pc_q;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign grant      = imem_req_o & imem_gnt_i;
  // Responses with nothing outstanding belong to pre-reset requests.
  assign rsp_acc    = imem_rvalid_i & (out_cnt_q != '0);
  assign rsp_live   = rsp_acc & (stale_cnt_q == '0) & ~jump_flag_i;
  assign pop        = ~fifo_empty & ~hold_i & ~jump_flag_i;

`ifdef INST_FETCH_BYPASS_EN
  logic bypass;
  assign bypass = rsp_live & fifo_empty;
  // A bypassed word consumed by decode this cycle is not buffered.
  assign push   = rsp_live & ~(bypass & ~hold_i);
`else
  assign push   = rsp_live;
`endif

  // Present the FIFO head (or the bypassed response) to decode, NOP when idle.
  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP;
    inst_addr_o  = '0;
    if (rst_n_i) begin
      if (!fifo_empty) begin
        inst_valid_o = 1'b1;
        inst_o       = fifo_inst_q[rd_ptr_q];
        inst_addr_o  = fifo_addr_q[rd_ptr_q];
      end
`ifdef INST_FETCH_BYPASS_EN
      else if (bypass) begin
        inst_valid_o = 1'b1;
        inst_o       = imem_rdata_i;
        inst_addr_o  = resp_pc_q;
      end
`endif
    end
  end

  // Next-state for PCs, counters and FIFO pointers; a jump overrides everything.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    out_cnt_d   = out_cnt_q;
    stale_cnt_d = stale_cnt_q;
    fifo_cnt_d  = fifo_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (jump_flag_i) begin
      fetch_pc_d  = jump_target;
      resp_pc_d   = jump_target;
      out_cnt_d   = out_cnt_q - CNT_W'(rsp_acc);
      stale_cnt_d = out_cnt_q - CNT_W'(rsp_acc);
      fifo_cnt_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      out_cnt_d = out_cnt_q + CNT_W'(grant) - CNT_W'(rsp_acc);
      if (rsp_acc && (stale_cnt_q != '0)) begin
        stale_cnt_d = stale_cnt_q - CNT_W'(1);
      end
      if (rsp_live) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      out_cnt_q   <= '0;
      stale_cnt_q <= '0;
      fifo_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      out_cnt_q   <= out_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= resp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a behavioural instruction memory with random
// grant and latency, plus a scoreboard of the program-order instruction
// stream that decode must see (restarting at every reset or jump).

module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef INST_FETCH_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic        clock = 1'b0;
  logic        resetN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        jumpFlag;
  logic [31:0] jumpAddr;
  logic        hold;
  logic [31:0] inst;
  logic [31:0] instAddr;
  logic        instValid;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  pend_t       pendQ[$];
  exp_t        expQ[$];
  logic [31:0] nextExp;
  int          cyc;
  int          nChecks;
  int          nFails;
  int          tbInflight;
  int          consumed;
  int          latMin;
  int          latMax;
  int          gntPct;
  bit          drainMode;

  inst_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clock),
    .rst_n_i      (resetN),
    .imem_req_o   (imemReq),
    .imem_addr_o  (imemAddr),
    .imem_gnt_i   (imemGnt),
    .imem_rvalid_i(imemRvalid),
    .imem_rdata_i (imemRdata),
    .jump_flag_i  (jumpFlag),
    .jump_addr_i  (jumpAddr),
    .hold_i       (hold),
    .inst_o       (inst),
    .inst_addr_o  (instAddr),
    .inst_valid_o (instValid)
  );

  always #5 clock = ~clock;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus: drive inputs, model memory, update the expected stream.
  task automatic applyStimulus(input bit rstN, input bit hl, input bit jmp,
                               input logic [31:0] jaddr, input bit jumpOnRv,
                               output bit jumped);
    bit rv;
    bit grantSeen;
    bit accepted;
    @(negedge clock);
    rv         = (pendQ.size() > 0) && (pendQ[0].due <= cyc);
    imemRvalid = rv;
    imemRdata  = rv ? memWord(pendQ[0].addr) : $urandom();
    jumped     = jmp | (jumpOnRv & rv);
    resetN     = rstN;
    hold       = hl;
    jumpFlag   = jumped;
    jumpAddr   = jaddr;
    imemGnt    = !drainMode && (int'($urandom_range(1, 100)) <= gntPct);
    #1;
    grantSeen = imemReq && imemGnt;
    if (grantSeen) begin
      pendQ.push_back('{addr: imemAddr, due: cyc + int'($urandom_range(latMin, latMax))});
    end
    accepted = rv && (tbInflight > 0);
    if (rv) begin
      void'(pendQ.pop_front());
    end
    if (!rstN) begin
      tbInflight = 0;
      expQ.delete();
      nextExp = RESET_PC;
      if (pendQ.size() > 0) drainMode = 1'b1;
    end else begin
      tbInflight = tbInflight + int'(grantSeen) - int'(accepted);
      if (jumped) begin
        expQ.delete();
        nextExp = {jaddr[31:2], 2'b00};
      end
    end
    if (pendQ.size() == 0) drainMode = 1'b0;
    while (expQ.size() < 16) begin
      expQ.push_back({nextExp, memWord(nextExp)});
      nextExp = nextExp + 32'd4;
    end
    cyc++;
  endtask

  task automatic runCycles(input int n, input int holdPct);
    bit j;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, int'($urandom_range(1, 100)) <= holdPct, 1'b0, 32'd0, 1'b0, j);
    end
  endtask

  task automatic waitInflight2(input string name);
    bit j;
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, j);
      if (tbInflight == 2) reached = 1'b1;
    end
    checkOutput(name, {31'd0, reached}, 32'd1);
  endtask

  // Monitor: compare what decode sees against the head of the expected stream.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (resetN === 1'b0) begin
        checkOutput("reset_valid", {31'd0, instValid}, 32'd0);
        checkOutput("reset_req", {31'd0, imemReq}, 32'd0);
        checkOutput("reset_inst", inst, NOP);
        checkOutput("reset_addr", instAddr, 32'd0);
      end else if (resetN === 1'b1) begin
        if (jumpFlag) checkOutput("jump_req", {31'd0, imemReq}, 32'd0);
        if (imemReq) checkOutput("req_align", {30'd0, imemAddr[1:0]}, 32'd0);
        checkOutput("inflight_bound", {31'd0, tbInflight <= DEPTH}, 32'd1);
        if (instValid && !jumpFlag) begin
          if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", instAddr, 32'hFFFF_FFFF);
          end else begin
            checkOutput("inst_addr", instAddr, expQ[0].addr);
            checkOutput("inst_word", inst, expQ[0].word);
            if (!hold) begin
              void'(expQ.pop_front());
              consumed++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit j;
    bit jumpedOnRv;
    int startConsumed;
    resetN = 1'b0; hold = 1'b0; jumpFlag = 1'b0; jumpAddr = '0;
    imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    cyc = 0; nChecks = 0; nFails = 0; tbInflight = 0; consumed = 0;
    latMin = 1; latMax = 1; gntPct = 100; drainMode = 1'b0; nextExp = RESET_PC;

    $display("[TB] reset and zero-wait latency");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, j);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, j);
      #1;
      if (c == 0) begin
        checkOutput("first_req", {31'd0, imemReq}, 32'd1);
        checkOutput("first_req_addr", imemAddr, RESET_PC);
      end
      if (c == 1) checkOutput("second_req_addr", imemAddr, RESET_PC + 32'd4);
      if (c < FIRST_VALID) begin
        checkOutput("lat_not_yet", {31'd0, instValid}, 32'd0);
      end else if (c == FIRST_VALID) begin
        checkOutput("lat_valid", {31'd0, instValid}, 32'd1);
        checkOutput("lat_addr", instAddr, RESET_PC);
      end
    end

    $display("[TB] hold for 5 cycles");
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, j);
    runCycles(5, 0);

    $display("[TB] jump to 0x203 with two requests in flight");
    latMin = 3; latMax = 3;
    waitInflight2("inflight2_before_jump");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b0, j);
    runCycles(15, 0);

    $display("[TB] jump coinciding with a live response");
    latMin = 1; latMax = 1;
    runCycles(8, 0);
    jumpedOnRv = 1'b0;
    for (int i = 0; i < 20 && !jumpedOnRv; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b1, jumpedOnRv);
    end
    checkOutput("jump_on_rvalid_seen", {31'd0, jumpedOnRv}, 32'd1);
    runCycles(10, 0);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, j);
    startConsumed = consumed;
    runCycles(12, 0);
    checkOutput("wrap_progress", {31'd0, (consumed - startConsumed) >= 3}, 32'd1);

    $display("[TB] reset with two requests in flight");
    latMin = 3; latMax = 3;
    waitInflight2("inflight2_before_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, j);
    latMin = 1; latMax = 1;
    startConsumed = consumed;
    runCycles(20, 0);
    checkOutput("post_reset_progress", {31'd0, (consumed - startConsumed) >= 2}, 32'd1);

    $display("[TB] randomized traffic");
    latMin = 1; latMax = 4; gntPct = 75;
    startConsumed = consumed;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      applyStimulus(r != 0, $urandom_range(0, 3) == 0, (r >= 1) && (r < 4),
                    $urandom(), 1'b0, j);
    end
    checkOutput("random_progress", {31'd0, (consumed - startConsumed) >= 40}, 32'd1);
    runCycles(10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
